// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the execute stage
//   alu_op_e     : ALU operation select (11-15 yield zero)
//   md_op_e      : multiply/divide operation select
//   FWD_*        : forwarding mux selects (2'b11 behaves as register data)
//   div_state_e  : iterative divider FSM states
//   fwd_mux()    : operand forwarding selection
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] reg_data,
                                          input logic [31:0] ex_mem_data,
                                          input logic [31:0] mem_wb_data);
    case (sel)
      FWD_MEM_WB: return mem_wb_data;
      FWD_EX_MEM: return ex_mem_data;
      default:    return reg_data;
    endcase
  endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider, one quotient bit per cycle
//   clk, rstn            : clock, async active-low reset
//   start                : accept operands (honoured only in IDLE)
//   abort                : drop any operation, return to IDLE
//   is_signed            : signed (DIV/REM) vs unsigned (DIVU/REMU)
//   dividend, divisor    : operands, sampled on start
//   busy, done           : FSM in DIV_BUSY / DIV_DONE
//   quotient, remainder  : results, valid while done
module div_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state;
  logic [4:0]  count;
  logic [31:0] acc;
  logic [31:0] quot;
  logic [31:0] divisor_q;
  logic [31:0] dividend_q;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic [32:0] diff;

  // Magnitudes are divided unsigned; signs are reapplied on the way out.
  assign abs_a   = (is_signed && dividend[31]) ? -dividend : dividend;
  assign abs_b   = (is_signed && divisor[31])  ? -divisor  : divisor;
  assign shifted = {acc, quot[31]};
  assign diff    = shifted - {1'b0, divisor_q};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      count      <= '0;
      acc        <= '0;
      quot       <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= DIV_BUSY;
            count      <= '0;
            acc        <= '0;
            quot       <= abs_a;
            divisor_q  <= abs_b;
            dividend_q <= dividend;
            neg_q      <= is_signed & (dividend[31] ^ divisor[31]);
            neg_r      <= is_signed & dividend[31];
            div_zero   <= (divisor == 32'd0);
          end
        end
        DIV_BUSY: begin
          // Dividend bits shift out of quot while quotient bits shift in.
          acc   <= diff[32] ? shifted[31:0] : diff[31:0];
          quot  <= {quot[30:0], ~diff[32]};
          count <= count + 5'd1;
          if (count == 5'd31) state <= DIV_DONE;
        end
        DIV_DONE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);

  // Divide-by-zero bypasses sign fix-up. Signed overflow (MIN / -1) needs no
  // special case: |MIN| = 0x80000000 unsigned, and the signs cancel.
  assign quotient  = div_zero ? 32'hFFFF_FFFF : (neg_q ? -quot : quot);
  assign remainder = div_zero ? dividend_q    : (neg_r ? -acc  : acc);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - pipeline execute stage: forwarding, ALU, mul/div, EX/MEM register
//   clk, rstn                      : clock, async active-low reset
//   id_ex_*                        : ID/EX register contents (operands, controls)
//   forward_a, forward_b           : operand forwarding selects
//   ex_mem_fwd_data, mem_wb_fwd_data : forwarding sources
//   flush                          : discard the EX instruction, abort divides
//   ex_stall                       : upstream hold while a divide runs
//   ex_mem_*                       : EX/MEM register outputs
module ex_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_ex_valid,
  input  logic [31:0] id_ex_rs1_data,
  input  logic [31:0] id_ex_rs2_data,
  input  logic [31:0] id_ex_imm,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_reg_write,
  input  logic        id_ex_mem_read,
  input  logic        id_ex_mem_write,
  input  logic        id_ex_alu_src_b,
  input  logic        id_ex_md_en,
  input  logic [3:0]  id_ex_alu_op,
  input  logic [2:0]  id_ex_md_op,
  input  logic [1:0]  forward_a,
  input  logic [1:0]  forward_b,
  input  logic [31:0] ex_mem_fwd_data,
  input  logic [31:0] mem_wb_fwd_data,
  input  logic        flush,
  output logic        ex_stall,
  output logic        ex_mem_valid,
  output logic        ex_mem_reg_write,
  output logic        ex_mem_mem_read,
  output logic        ex_mem_mem_write,
  output logic [4:0]  ex_mem_rd,
  output logic [31:0] ex_mem_result,
  output logic [31:0] ex_mem_store_data
);

  logic [31:0] op_a, rs2_fwd, op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res, md_res, ex_result;
  logic [63:0] mul_a, mul_b, product;
  logic        is_div, div_accept;
  logic        div_busy, div_done;
  logic [31:0] div_quot, div_rem;

  assign op_a    = fwd_mux(forward_a, id_ex_rs1_data, ex_mem_fwd_data, mem_wb_fwd_data);
  assign rs2_fwd = fwd_mux(forward_b, id_ex_rs2_data, ex_mem_fwd_data, mem_wb_fwd_data);
  assign op_b    = id_ex_alu_src_b ? id_ex_imm : rs2_fwd;
  assign shamt   = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(id_ex_alu_op))
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_SLL:    alu_res = op_a << shamt;
      ALU_SLT:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   alu_res = {31'd0, op_a < op_b};
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_SRL:    alu_res = op_a >> shamt;
      ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:     alu_res = op_a | op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_PASS_B: alu_res = op_b;
      default:    alu_res = '0;
    endcase
  end

  // One 64x64 product covers all four multiplies; the operand extension
  // picks the signedness (MULH: both signed, MULHSU: only rs1 signed).
  assign mul_a   = {{32{op_a[31]    & (id_ex_md_op[1:0] inside {2'd1, 2'd2})}}, op_a};
  assign mul_b   = {{32{rs2_fwd[31] & (id_ex_md_op[1:0] == 2'd1)}}, rs2_fwd};
  assign product = mul_a * mul_b;
  assign md_res  = (id_ex_md_op[1:0] == 2'd0) ? product[31:0] : product[63:32];

  assign ex_result = id_ex_md_en ? md_res : alu_res;

  assign is_div     = id_ex_md_en & id_ex_md_op[2];
  assign div_accept = id_ex_valid & is_div & ~flush & ~div_busy & ~div_done;
  assign ex_stall   = rstn & (div_accept | div_busy);

  div_unit u_div (
    .clk       (clk),
    .rstn      (rstn),
    .start     (div_accept),
    .abort     (flush),
    .is_signed (~id_ex_md_op[0]),
    .dividend  (op_a),
    .divisor   (rs2_fwd),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  // While stalled, ID/EX holds the divide, so in DIV_DONE its controls and
  // md_op (quotient vs remainder) are still presented on the inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      ex_mem_rd         <= '0;
      ex_mem_result     <= '0;
      ex_mem_store_data <= '0;
    end else if (flush || ex_stall || !id_ex_valid) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      ex_mem_rd         <= '0;
      ex_mem_result     <= '0;
      ex_mem_store_data <= '0;
    end else begin
      ex_mem_valid      <= 1'b1;
      ex_mem_reg_write  <= id_ex_reg_write & (id_ex_rd != 5'd0);
      ex_mem_mem_read   <= id_ex_mem_read;
      ex_mem_mem_write  <= id_ex_mem_write;
      ex_mem_rd         <= id_ex_rd;
      ex_mem_result     <= div_done ? (id_ex_md_op[1] ? div_rem : div_quot) : ex_result;
      ex_mem_store_data <= rs2_fwd;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

  logic        clk;
  logic        rstn;
  logic        id_ex_valid;
  logic [31:0] id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rd;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src_b, id_ex_md_en;
  logic [3:0]  id_ex_alu_op;
  logic [2:0]  id_ex_md_op;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] ex_mem_fwd_data, mem_wb_fwd_data;
  logic        flush;
  logic        ex_stall;
  logic        ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
  logic [4:0]  ex_mem_rd;
  logic [31:0] ex_mem_result, ex_mem_store_data;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] store;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  ex_stage dut (
    .clk               (clk),
    .rstn              (rstn),
    .id_ex_valid       (id_ex_valid),
    .id_ex_rs1_data    (id_ex_rs1_data),
    .id_ex_rs2_data    (id_ex_rs2_data),
    .id_ex_imm         (id_ex_imm),
    .id_ex_rd          (id_ex_rd),
    .id_ex_reg_write   (id_ex_reg_write),
    .id_ex_mem_read    (id_ex_mem_read),
    .id_ex_mem_write   (id_ex_mem_write),
    .id_ex_alu_src_b   (id_ex_alu_src_b),
    .id_ex_md_en       (id_ex_md_en),
    .id_ex_alu_op      (id_ex_alu_op),
    .id_ex_md_op       (id_ex_md_op),
    .forward_a         (forward_a),
    .forward_b         (forward_b),
    .ex_mem_fwd_data   (ex_mem_fwd_data),
    .mem_wb_fwd_data   (mem_wb_fwd_data),
    .flush             (flush),
    .ex_stall          (ex_stall),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_reg_write  (ex_mem_reg_write),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_mem_write  (ex_mem_mem_write),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_result     (ex_mem_result),
    .ex_mem_store_data (ex_mem_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] alu, input logic md, input logic [2:0] mdop,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                           input logic srcb, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic mw);
    id_ex_valid     = 1'b1;
    id_ex_alu_op    = alu;
    id_ex_md_en     = md;
    id_ex_md_op     = mdop;
    id_ex_rs1_data  = rs1;
    id_ex_rs2_data  = rs2;
    id_ex_imm       = imm;
    id_ex_alu_src_b = srcb;
    id_ex_rd        = rd;
    id_ex_reg_write = rw;
    id_ex_mem_read  = mr;
    id_ex_mem_write = mw;
    forward_a       = 2'b00;
    forward_b       = 2'b00;
    ex_mem_fwd_data = '0;
    mem_wb_fwd_data = '0;
    flush           = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] result, input logic [31:0] store, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
    exp_t e;
    e.valid  = 1'b1;
    e.rw     = rw;
    e.mr     = mr;
    e.mw     = mw;
    e.rd     = rd;
    e.result = result;
    e.store  = store;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, " valid"},      {31'd0, ex_mem_valid},     {31'd0, e.valid});
      chk({tag, " reg_write"},  {31'd0, ex_mem_reg_write}, {31'd0, e.rw});
      chk({tag, " mem_rd/wr"},  {30'd0, ex_mem_mem_read, ex_mem_mem_write}, {30'd0, e.mr, e.mw});
      chk({tag, " rd"},         {27'd0, ex_mem_rd},        {27'd0, e.rd});
      chk({tag, " result"},     ex_mem_result,             e.result);
      chk({tag, " store_data"}, ex_mem_store_data,         e.store);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " valid"},  {31'd0, ex_mem_valid}, 32'd0);
    chk({tag, " enables"}, {29'd0, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}, 32'd0);
    chk({tag, " result"}, ex_mem_result, 32'd0);
    chk({tag, " stall"},  {31'd0, ex_stall}, 32'd0);
  endtask

  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_val, input string tag);
    int n;
    int bub;
    n = 0;
    bub = 0;
    set_instr(4'd0, 1'b1, op, a, b, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    push_exp(exp_val, b, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    chk({tag, " stall at accept"}, {31'd0, ex_stall}, 32'd1);
    while (ex_stall === 1'b1 && n < 100) begin
      tick();
      n++;
      if (ex_mem_valid !== 1'b0 || ex_mem_reg_write !== 1'b0 || ex_mem_mem_read !== 1'b0 ||
          ex_mem_mem_write !== 1'b0) bub++;
    end
    chk({tag, " stall cycles"}, n, 33);
    chk({tag, " bubbles while stalled"}, bub, 0);
    tick();
    check_out(tag);
    id_ex_valid = 1'b0;
  endtask

  task automatic quiet_run(input string tag);
    int seen;
    seen = 0;
    id_ex_valid = 1'b0;
    repeat (40) begin
      tick();
      if (ex_mem_valid !== 1'b0) seen++;
      if (ex_stall !== 1'b0) seen++;
    end
    chk({tag, " no late result"}, seen, 0);
  endtask

  initial begin
    rstn = 1'b1;
    set_instr(4'd0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    id_ex_valid = 1'b0;
    #1 rstn = 1'b0;
    #1;
    check_zero("reset");
    tick();
    tick();
    rstn = 1'b1;

    // Forward EX/MEM into A, ADD immediate
    set_instr(4'd0, 1'b0, 3'd0, 32'd5, 32'h55, 32'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    forward_a = 2'b10;
    ex_mem_fwd_data = 32'd9;
    push_exp(32'd10, 32'h55, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("add fwd ex_mem");

    // A from MEM/WB, B from EX/MEM, SUB
    set_instr(4'd1, 1'b0, 3'd0, 32'd100, 32'd200, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    forward_a = 2'b01;
    forward_b = 2'b10;
    mem_wb_fwd_data = 32'd20;
    ex_mem_fwd_data = 32'd7;
    push_exp(32'd13, 32'd7, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("sub fwd mixed");

    // Select 11 uses register data
    set_instr(4'd1, 1'b0, 3'd0, 32'd40, 32'd15, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    forward_a = 2'b11;
    forward_b = 2'b11;
    mem_wb_fwd_data = 32'd1000;
    ex_mem_fwd_data = 32'd2000;
    push_exp(32'd25, 32'd15, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("sub fwd 11");

    // ALU ops, back-to-back
    set_instr(4'd3, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    push_exp(32'd1, 32'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("slt");
    set_instr(4'd4, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    push_exp(32'd0, 32'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("sltu");
    set_instr(4'd7, 1'b0, 3'd0, 32'h8000_0000, 32'h1234, 32'h0000_0024, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    push_exp(32'hF800_0000, 32'h1234, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("sra shamt b4:0");
    set_instr(4'd0, 1'b0, 3'd0, 32'h1000, 32'hCAFE_F00D, 32'h10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    push_exp(32'h1010, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("store addr");
    set_instr(4'd10, 1'b0, 3'd0, 32'h1, 32'h2, 32'hABCD, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
    push_exp(32'hABCD, 32'h2, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("pass b");
    set_instr(4'd12, 1'b0, 3'd0, 32'h1, 32'h2, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    push_exp(32'd0, 32'h2, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("alu op 12");

    // Multiplies, rd=0 suppresses reg_write
    set_instr(4'd0, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push_exp(32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("mulhu rd0");
    set_instr(4'd0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    push_exp(32'd0, 32'hFFFF_FFFF, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("mulh");
    set_instr(4'd0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    push_exp(32'hFFFF_FFFF, 32'd2, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("mulhsu");
    set_instr(4'd0, 1'b1, 3'd0, 32'd12345, 32'd678, 32'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    push_exp(32'd8369910, 32'd678, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("mul");

    // Invalid instruction becomes a bubble
    id_ex_valid = 1'b0;
    tick();
    chk("invalid bubble valid", {31'd0, ex_mem_valid}, 32'd0);

    // Divides
    run_div(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div -7/2");
    run_div(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem -7/2");
    run_div(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, "divu by0");
    run_div(3'd7, 32'd100, 32'd0, 32'd100, "remu by0");
    run_div(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div ovf");
    run_div(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem ovf");
    run_div(3'd5, 32'd1000, 32'd7, 32'd142, "divu 1000/7");

    // Flush at busy cycle 10
    set_instr(4'd0, 1'b1, 3'd4, 32'd100, 32'd3, 32'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    repeat (9) tick();
    chk("flush pre stall", {31'd0, ex_stall}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    id_ex_valid = 1'b0;
    #1;
    chk("flush stall low", {31'd0, ex_stall}, 32'd0);
    chk("flush bubble", {31'd0, ex_mem_valid}, 32'd0);
    quiet_run("flush");

    // Flush wins over a simultaneous divide accept
    set_instr(4'd0, 1'b1, 3'd5, 32'd50, 32'd5, 32'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush vs accept stall", {31'd0, ex_stall}, 32'd0);
    tick();
    chk("flush vs accept bubble", {31'd0, ex_mem_valid}, 32'd0);
    flush = 1'b0;
    id_ex_valid = 1'b0;
    #1;
    chk("flush vs accept idle", {31'd0, ex_stall}, 32'd0);

    // Reset at busy cycle 5
    set_instr(4'd0, 1'b1, 3'd4, 32'd77, 32'd5, 32'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
    tick();
    repeat (4) tick();
    chk("reset mid pre stall", {31'd0, ex_stall}, 32'd1);
    rstn = 1'b0;
    #1;
    check_zero("reset mid div");
    id_ex_valid = 1'b0;
    tick();
    rstn = 1'b1;
    quiet_run("reset mid div");

    // Reset clears a live EX/MEM value immediately
    set_instr(4'd8, 1'b0, 3'd0, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0);
    push_exp(32'hF0F0_0F0F, 32'h0000_0F0F, 5'd15, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("or");
    id_ex_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check_zero("reset after or");
    chk("reset store_data", ex_mem_store_data, 32'd0);
    tick();
    rstn = 1'b1;

    chk("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rstn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: id_ex_valid  in  1  ID/EX holds a real instruction.
REQ-004 SHALL have ports: id_ex_rs1_data, id_ex_rs2_data, id_ex_imm  in  32 each  register-file operands, immediate.
REQ-005 SHALL have ports: id_ex_rd  in  5; id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src_b, id_ex_md_en  in  1 each  control bits.
REQ-006 SHALL have ports: id_ex_alu_op  in  4; id_ex_md_op  in  3  operation selects.
REQ-007 SHALL have ports: forward_a, forward_b  in  2  00 register data, 01 MEM/WB data, 10 EX/MEM data, 11 treated as 00.
REQ-008 SHALL have ports: ex_mem_fwd_data, mem_wb_fwd_data  in  32  forwarding sources.
REQ-009 SHALL have ports: flush  in  1  discard the EX instruction.
REQ-010 SHALL have ports: ex_stall  out  1  upstream stages hold while high.
REQ-011 SHALL have ports: ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write  out  1 each; ex_mem_rd  out  5; ex_mem_result, ex_mem_store_data  out  32  EX/MEM register.

Function
REQ-012 SHALL select operand A from forward_a, and rs2 value from forward_b; operand B = id_ex_imm when id_ex_alu_src_b else forwarded rs2; ex_mem_store_data = forwarded rs2.
REQ-013 SHALL implement alu_op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass B; 11-15 produce 0; shifts use B[4:0]; arithmetic mod 2^32.
REQ-014 SHALL implement md_op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU in one cycle; 4 DIV, 5 DIVU, 6 REM, 7 REMU iteratively.
REQ-015 SHALL use FSM IDLE -> DIV_BUSY -> DIV_DONE -> IDLE; IDLE->DIV_BUSY on valid, unflushed divide with ex_stall high that cycle; operands latched then.
REQ-016 SHALL spend exactly 32 cycles in DIV_BUSY (one quotient bit per cycle), then one cycle in DIV_DONE with ex_stall low, EX/MEM capturing the result; total 34 cycles from accept to EX/MEM update.
REQ-017 SHALL keep ex_stall high in IDLE(accept cycle) and DIV_BUSY, low otherwise; EX/MEM SHALL capture a bubble (valid and all enables 0) on every stalled edge.
REQ-018 SHALL return on divide-by-zero quotient 0xFFFFFFFF, remainder = dividend; on signed 0x80000000 / -1 quotient 0x80000000, remainder 0.
REQ-019 SHALL, on flush, abort any divide, go to IDLE, deassert ex_stall next cycle, and load a bubble into EX/MEM; flush wins over simultaneous divide accept.
REQ-020 SHALL, for non-divide valid instructions, update EX/MEM on the next edge (1-cycle latency); id_ex_valid=0 loads a bubble.
REQ-021 SHALL force ex_mem_reg_write=0 when rd=0 is written.

Reset
REQ-022 SHALL, while rstn=0, immediately clear all EX/MEM outputs to 0, state to IDLE, ex_stall to 0, divider registers to 0.
REQ-023 SHALL abandon a divide in progress when reset asserts mid-operation; no result emerges after release.

Structure
REQ-024 SHALL place alu_op and md_op encodings, forward-select constants and FSM state encodings in shared package cpu_pkg.
REQ-025 SHALL implement the iterative divider as sub-module div_unit (start, signed, operands in; busy, done, quotient, remainder out).

Verification
REQ-026 rs1=5, EX/MEM data=9, forward_a=10, ADD imm 1 -> ex_mem_result=10 next cycle.
REQ-027 forward_a=01, forward_b=10, SUB, MEM/WB=20, EX/MEM=7 -> result 13; forward=11 uses register data.
REQ-028 DIV -7/2 -> ex_stall high 33 cycles, bubbles meanwhile, then result 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-029 DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIV 0x80000000/-1 -> 0x80000000.
REQ-030 flush at busy cycle 10 -> ex_stall low next cycle, bubble, no later result; rstn low at busy cycle 5 -> outputs 0 at once.
REQ-031 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE in 1 cycle; rd=0 with reg_write -> ex_mem_reg_write=0.
